// File: rtl/sdma_shuffle_packer.sv
// SDMA shuffle packer: gathers byte [7:0] of each shuffled word
// into cache-width lines and emits them on a valid/ready port.
`ifndef SDMA_CACHEDATAWIDTH
`define SDMA_CACHEDATAWIDTH 512
`endif

module sdma_shuffle_packer #(
  parameter int DATAW = `SDMA_CACHEDATAWIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ssp_valid,
  output logic             o_ssp_ready,
  input  logic [DATAW-1:0] i_ssp_data,
  input  logic             i_ssp_last,
  output logic             o_ssp_valid,
  input  logic             i_ssp_ready,
  output logic [DATAW-1:0] o_ssp_data,
  output logic [$clog2(DATAW/8):0] o_ssp_bytecnt,
  output logic             o_ssp_last
);

  localparam int LANES = DATAW / 8;
  localparam int CNTW  = $clog2(LANES) + 1;
  localparam int CW    = CNTW - 1;

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e            state_q;
  logic [DATAW-1:0]  line_q;
  logic [CW-1:0]     cnt_q;
  logic [CNTW-1:0]   hcnt_q;
  logic              hlast_q;
  logic [DATAW-1:0]  odata_q;
  logic [CNTW-1:0]   ocnt_q;
  logic              olast_q;
  logic              oval_q;

  logic [DATAW-1:0]  line_d;
  logic [CNTW-1:0]   cnt_d;
  logic              accept;
  logic              complete;
  logic              out_free;
  logic              unused_hi;

  assign unused_hi   = ^i_ssp_data[DATAW-1:8];
  assign o_ssp_ready = (state_q == ACCUM) && !i_rst;
  assign accept      = i_ssp_valid && o_ssp_ready;
  assign complete    = accept &&
                       ((cnt_q == CW'(LANES - 1)) || i_ssp_last);
  assign out_free    = !oval_q || i_ssp_ready;
  assign cnt_d       = {1'b0, cnt_q} + CNTW'(1);

  assign o_ssp_valid   = oval_q;
  assign o_ssp_data    = odata_q;
  assign o_ssp_bytecnt = ocnt_q;
  assign o_ssp_last    = olast_q;

  // Accumulator line with the incoming byte merged into lane cnt.
  always_comb begin
    line_d = line_q;
    line_d[{cnt_q, 3'b000} +: 8] = i_ssp_data[7:0];
  end

  // Packing FSM, accumulator and registered output stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ACCUM;
      line_q  <= '0;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      hlast_q <= 1'b0;
      odata_q <= '0;
      ocnt_q  <= '0;
      olast_q <= 1'b0;
      oval_q  <= 1'b0;
    end else begin
      if (oval_q && i_ssp_ready) begin
        oval_q <= 1'b0;
      end
      unique case (state_q)
        ACCUM: begin
          if (complete && out_free) begin
            odata_q <= line_d;
            ocnt_q  <= cnt_d;
            olast_q <= i_ssp_last;
            oval_q  <= 1'b1;
            line_q  <= '0;
            cnt_q   <= '0;
          end else if (complete) begin
            line_q  <= line_d;
            hcnt_q  <= cnt_d;
            hlast_q <= i_ssp_last;
            state_q <= HOLD;
          end else if (accept) begin
            line_q <= line_d;
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        HOLD: begin
          if (out_free) begin
            odata_q <= line_q;
            ocnt_q  <= hcnt_q;
            olast_q <= hlast_q;
            oval_q  <= 1'b1;
            line_q  <= '0;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            hlast_q <= 1'b0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sdma_shuffle_packer.sv
// Directed bench for sdma_shuffle_packer: vector table plus
// hand-written stall, back-to-back and reset sequences.
module tb_sdma_shuffle_packer;

  localparam int DATAW = 512;
  localparam int CNTW  = 7;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_ssp_valid = 1'b0;
  logic             o_ssp_ready;
  logic [DATAW-1:0] i_ssp_data = '0;
  logic             i_ssp_last = 1'b0;
  logic             o_ssp_valid;
  logic             i_ssp_ready = 1'b1;
  logic [DATAW-1:0] o_ssp_data;
  logic [CNTW-1:0]  o_ssp_bytecnt;
  logic             o_ssp_last;

  sdma_shuffle_packer #(.DATAW(DATAW)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_ssp_valid   (i_ssp_valid),
    .o_ssp_ready   (o_ssp_ready),
    .i_ssp_data    (i_ssp_data),
    .i_ssp_last    (i_ssp_last),
    .o_ssp_valid   (o_ssp_valid),
    .i_ssp_ready   (i_ssp_ready),
    .o_ssp_data    (o_ssp_data),
    .o_ssp_bytecnt (o_ssp_bytecnt),
    .o_ssp_last    (o_ssp_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATAW-1:0] d;
    logic [CNTW-1:0]  c;
    logic             l;
    int               cyc;
  } line_t;

  typedef struct {
    int              n;
    logic [7:0]      base;
    bit              last;
    bit              ones;
    int              gap;
    logic [CNTW-1:0] ecnt;
    bit              elast;
    logic [63:0]     elo;
  } vec_t;

  line_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drops = 0;
  bit watch = 1'b0;
  bit stall = 1'b0;
  logic [DATAW-1:0] sd;
  logic [CNTW-1:0]  sc;
  logic             sl;

  task automatic chk(input string nm,
                     input logic [DATAW-1:0] act,
                     input logic [DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] mk(int n, logic [7:0] base);
    logic [DATAW-1:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*8 +: 8] = base + 8'(k);
    return r;
  endfunction

  // Output collector and hold-stability monitor.
  always @(negedge clk) begin
    cyc++;
    if (i_rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        checks++;
        if (o_ssp_valid !== 1'b1 || o_ssp_data !== sd ||
            o_ssp_bytecnt !== sc || o_ssp_last !== sl) begin
          failures++;
          $display("FAIL stall_stable got=%0h/%0d want=%0h/%0d",
                   o_ssp_data, o_ssp_bytecnt, sd, sc);
        end
      end
      if (o_ssp_valid && i_ssp_ready)
        q.push_back('{o_ssp_data, o_ssp_bytecnt, o_ssp_last, cyc});
      stall = o_ssp_valid && !i_ssp_ready;
      sd = o_ssp_data;
      sc = o_ssp_bytecnt;
      sl = o_ssp_last;
      if (watch && !o_ssp_ready) drops++;
    end
  end

  task automatic send(input logic [7:0] b, input bit lst, input bit ones);
    int t;
    i_ssp_valid = 1'b1;
    i_ssp_last  = lst;
    i_ssp_data  = ones ? {{(DATAW-8){1'b1}}, b} : {{(DATAW-8){1'b0}}, b};
    t = 0;
    @(negedge clk);
    while (!o_ssp_ready && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (!o_ssp_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=ready0 want=ready1");
    end
    @(posedge clk);
    #1;
    i_ssp_valid = 1'b0;
    i_ssp_last  = 1'b0;
    i_ssp_data  = '0;
  endtask

  task automatic send_run(input int n, input logic [7:0] base,
                          input bit lst, input bit ones, input int gap);
    for (int k = 0; k < n; k++) begin
      send(base + 8'(k), lst && (k == n - 1), ones);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic get_line(output line_t it);
    int t;
    t = 0;
    it = '{'0, '0, 1'b0, 0};
    while (q.size() == 0 && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL line_timeout got=none want=line");
    end else begin
      it = q.pop_front();
    end
  endtask

  vec_t tbl[5];
  line_t a;
  line_t b;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{64, 8'h00, 1'b1, 1'b0, 0, 7'd64, 1'b1,
               64'h0706050403020100};
    tbl[1] = '{5, 8'hA1, 1'b1, 1'b1, 0, 7'd5, 1'b1,
               64'h000000A5A4A3A2A1};
    tbl[2] = '{1, 8'h5A, 1'b1, 1'b0, 0, 7'd1, 1'b1,
               64'h000000000000005A};
    tbl[3] = '{3, 8'h10, 1'b1, 1'b0, 2, 7'd3, 1'b1,
               64'h0000000000121110};
    tbl[4] = '{64, 8'h40, 1'b0, 1'b0, 0, 7'd64, 1'b0,
               64'h4746454443424140};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", o_ssp_ready, 0);
    chk("rst_valid", o_ssp_valid, 0);
    chk("rst_data", o_ssp_data, 0);
    chk("rst_cnt", o_ssp_bytecnt, 0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", o_ssp_ready, 1);
    chk("rel_valid", o_ssp_valid, 0);
    @(posedge clk);
    #1;

    // Vector table with downstream always ready
    for (int v = 0; v < 5; v++) begin
      send_run(tbl[v].n, tbl[v].base, tbl[v].last, tbl[v].ones, 0);
      if (tbl[v].gap > 0) begin
        for (int k = 0; k < tbl[v].n; k++) begin end
      end
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_latency", v), q.size(), 1);
      get_line(a);
      chk($sformatf("v%0d_data", v), a.d, mk(tbl[v].n, tbl[v].base));
      chk($sformatf("v%0d_lo", v), a.d[63:0], tbl[v].elo);
      chk($sformatf("v%0d_cnt", v), a.c, tbl[v].ecnt);
      chk($sformatf("v%0d_last", v), a.l, tbl[v].elast);
      @(posedge clk);
      #1;
    end

    // Idle gaps between bytes leave the accumulator untouched
    send_run(3, 8'h10, 1'b1, 1'b0, 2);
    get_line(a);
    chk("gap_data", a.d, mk(3, 8'h10));
    chk("gap_cnt", a.c, 3);
    @(posedge clk);
    #1;

    // Two full lines against a stalled output -> HOLD
    i_ssp_ready = 1'b0;
    send_run(128, 8'h00, 1'b0, 1'b0, 0);
    @(negedge clk);
    #1;
    chk("hold_ready", o_ssp_ready, 0);
    chk("hold_valid", o_ssp_valid, 1);
    chk("hold_cnt", o_ssp_bytecnt, 64);
    chk("hold_noq", q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    i_ssp_ready = 1'b1;
    get_line(a);
    get_line(b);
    chk("hold_l1", a.d, mk(64, 8'h00));
    chk("hold_l1_cnt", a.c, 64);
    chk("hold_l1_last", a.l, 0);
    chk("hold_l2", b.d, mk(64, 8'h40));
    chk("hold_l2_cnt", b.c, 64);
    chk("hold_l2_last", b.l, 0);
    chk("hold_b2b", b.cyc - a.cyc, 1);
    @(negedge clk);
    #1;
    chk("hold_exit_ready", o_ssp_ready, 1);
    @(posedge clk);
    #1;

    // Drain of a pending line coincides with next completion
    i_ssp_ready = 1'b0;
    send_run(64, 8'hC0, 1'b0, 1'b0, 0);
    watch = 1'b1;
    send_run(63, 8'h20, 1'b0, 1'b0, 0);
    i_ssp_ready = 1'b1;
    send(8'h5F, 1'b0, 1'b0);
    get_line(a);
    get_line(b);
    watch = 1'b0;
    chk("sim_a", a.d, mk(64, 8'hC0));
    chk("sim_b", b.d, mk(64, 8'h20));
    chk("sim_b_cnt", b.c, 64);
    chk("sim_b2b", b.cyc - a.cyc, 1);
    chk("sim_drops", drops, 0);
    @(posedge clk);
    #1;

    // Reset mid-line discards partial data
    send_run(10, 8'h30, 1'b0, 1'b0, 0);
    i_rst = 1'b1;
    @(negedge clk);
    chk("mrst_ready", o_ssp_ready, 0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst_valid", o_ssp_valid, 0);
    chk("mrst_ready1", o_ssp_ready, 1);
    chk("mrst_noq", q.size(), 0);
    @(posedge clk);
    #1;
    send_run(64, 8'h80, 1'b0, 1'b0, 0);
    get_line(a);
    chk("mrst_lane0", a.d[7:0], 8'h80);
    chk("mrst_data", a.d, mk(64, 8'h80));
    chk("mrst_cnt", a.c, 64);
    chk("mrst_last", a.l, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("end_noq", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
